// File: rtl/fir_drv_pkg.sv
// Shared defaults, state encoding and sizing helpers for the FIR frame driver.
package fir_drv_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_SAMP = 8;
    localparam int DEF_NUM_TAPS = 8;
    localparam int DEF_TIMEOUT  = 256;

    typedef enum logic [1:0] {IDLE, RUN, DONE} drv_state_t;

    // Width able to hold every value 0..n inclusive, so terminal counts fit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_NUM_SAMP);
endpackage

// File: rtl/drv_tx_serializer.sv
// Holds the captured frame and streams it sample by sample into the filter's din_rsc port.
module drv_tx_serializer
    import fir_drv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_SAMP = DEF_NUM_SAMP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       run,
    input  logic [NUM_SAMP*DATA_W-1:0] frame_in,
    input  logic                       din_rsc_rdy,
    output logic [DATA_W-1:0]          din_rsc_dat,
    output logic                       din_rsc_vld,
    output logic                       tx_fire,
    output logic                       tx_done
);
    localparam int CNT_W = cnt_width(NUM_SAMP);

    logic [NUM_SAMP*DATA_W-1:0] frame_q;
    logic [CNT_W-1:0]           tx_cnt_q;

    // The frame shifts down one sample per transfer, so the current sample is always the low slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q  <= '0;
            tx_cnt_q <= '0;
        end else if (load) begin
            frame_q  <= frame_in;
            tx_cnt_q <= '0;
        end else if (tx_fire) begin
            frame_q  <= frame_q >> DATA_W;
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
        end
    end

    assign tx_done     = (tx_cnt_q == CNT_W'(NUM_SAMP));
    assign din_rsc_vld = run && !tx_done;
    assign din_rsc_dat = din_rsc_vld ? frame_q[DATA_W-1:0] : '0;
    assign tx_fire     = din_rsc_vld && din_rsc_rdy;
endmodule

// File: rtl/fir_frame_driver.sv
// Frame-level driver for the streaming FIR: captures a frame, feeds the filter and collects its results.
module fir_frame_driver
    import fir_drv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_SAMP = DEF_NUM_SAMP,
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_SAMP*DATA_W-1:0] frame_in,
    input  logic [NUM_TAPS*DATA_W-1:0] coeff_in,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NUM_SAMP*DATA_W-1:0] frame_out,
    output logic [NUM_TAPS*DATA_W-1:0] coeffs,
    output logic [DATA_W-1:0]          din_rsc_dat,
    output logic                       din_rsc_vld,
    input  logic                       din_rsc_rdy,
    input  logic [DATA_W-1:0]          dout_rsc_dat,
    input  logic                       dout_rsc_vld,
    output logic                       dout_rsc_rdy
);
    localparam int CNT_W = cnt_width(NUM_SAMP);
    localparam int WD_W  = cnt_width(TIMEOUT);

    drv_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           rx_cnt_q;
    logic [WD_W-1:0]            wdog_q;
    logic                       err_q;
    logic [NUM_TAPS*DATA_W-1:0] coeffs_q;
    logic [NUM_SAMP*DATA_W-1:0] frame_out_q;

    logic accept, run, rx_fire, rx_last, tx_fire, tx_done, idle_cyc, timeout;
    logic unused_tx_done;

    assign accept   = (state_q == IDLE) && start;
    assign run      = (state_q == RUN);
    assign dout_rsc_rdy = run && (rx_cnt_q < CNT_W'(NUM_SAMP));
    assign rx_fire  = dout_rsc_vld && dout_rsc_rdy;
    assign rx_last  = rx_fire && (rx_cnt_q == CNT_W'(NUM_SAMP - 1));
    assign idle_cyc = run && !tx_fire && !rx_fire;
    assign timeout  = idle_cyc && (wdog_q == WD_W'(TIMEOUT - 1));
    assign unused_tx_done = tx_done;

    drv_tx_serializer #(
        .DATA_W   (DATA_W),
        .NUM_SAMP (NUM_SAMP)
    ) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .run         (run),
        .frame_in    (frame_in),
        .din_rsc_rdy (din_rsc_rdy),
        .din_rsc_dat (din_rsc_dat),
        .din_rsc_vld (din_rsc_vld),
        .tx_fire     (tx_fire),
        .tx_done     (tx_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (rx_last)      state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results land in the slot named by rx_cnt; the watchdog only advances on RUN cycles with no traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_q    <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            coeffs_q    <= '0;
            frame_out_q <= '0;
        end else if (accept) begin
            rx_cnt_q    <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            coeffs_q    <= coeff_in;
            frame_out_q <= '0;
        end else begin
            for (int k = 0; k < NUM_SAMP; k++) begin
                if (rx_fire && rx_cnt_q == CNT_W'(k))
                    frame_out_q[k*DATA_W +: DATA_W] <= dout_rsc_dat;
            end
            if (rx_fire) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            wdog_q <= idle_cyc ? wdog_q + WD_W'(1) : '0;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign coeffs    = coeffs_q;
    assign frame_out = frame_out_q;
endmodule

// File: tb/tb_fir_frame_driver.sv
// Bench for fir_frame_driver: loopback filter model (dout = din+1, latency 2), vector table and corner sequences.
module tb_fir_frame_driver;
    localparam int DATA_W   = 8;
    localparam int NUM_SAMP = 8;
    localparam int NUM_TAPS = 8;
    localparam int TIMEOUT  = 16;
    localparam int LAT      = 2;
    localparam int FW       = NUM_SAMP * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [FW-1:0]     frame_in = '0;
    logic [63:0]       coeff_in = '0;
    logic              busy, done, err;
    logic [FW-1:0]     frame_out;
    logic [63:0]       coeffs;
    logic [DATA_W-1:0] din_rsc_dat;
    logic              din_rsc_vld;
    logic              din_rsc_rdy = 1'b0;
    logic [DATA_W-1:0] dout_rsc_dat = '0;
    logic              dout_rsc_vld = 1'b0;
    logic              dout_rsc_rdy;

    always #5 clk = ~clk;

    fir_frame_driver #(
        .DATA_W   (DATA_W),
        .NUM_SAMP (NUM_SAMP),
        .NUM_TAPS (NUM_TAPS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_in     (frame_in),
        .coeff_in     (coeff_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .frame_out    (frame_out),
        .coeffs       (coeffs),
        .din_rsc_dat  (din_rsc_dat),
        .din_rsc_vld  (din_rsc_vld),
        .din_rsc_rdy  (din_rsc_rdy),
        .dout_rsc_dat (dout_rsc_dat),
        .dout_rsc_vld (dout_rsc_vld),
        .dout_rsc_rdy (dout_rsc_rdy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] pipe[$];
    int                pipe_t[$];
    int rdy_mode = 0, vld_mode = 0, max_results = NUM_SAMP, res_made = 0;
    int tx_seen = 0, rx_seen = 0, done_seen = 0, last_xfer = 0, coeff_bad = 0;
    bit extra_result = 0, prev_tx = 0, prev_rx = 0, prev_vld = 0;
    logic [DATA_W-1:0] prev_dat = '0;
    logic [63:0]       exp_coeffs = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Filter model and monitor: everything driven and sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            pipe.delete();
            pipe_t.delete();
            prev_tx = 0; prev_rx = 0; prev_vld = 0;
            din_rsc_rdy = 1'b0; dout_rsc_vld = 1'b0; dout_rsc_dat = '0;
        end else begin
            if (prev_tx) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL tx_unexpected: got %h expected none", prev_dat);
                end else begin
                    check_output("tx_dat", prev_dat, sb.pop_front());
                end
                tx_seen++;
                last_xfer = cyc;
                if (res_made < max_results) begin
                    pipe.push_back(prev_dat + 8'd1);
                    pipe_t.push_back(cyc + LAT - 1);
                    res_made++;
                end
                if (extra_result && tx_seen == NUM_SAMP) begin
                    pipe.push_back(8'hEE);
                    pipe_t.push_back(cyc + LAT - 1);
                end
            end else if (prev_vld) begin
                check_output("vld_hold", din_rsc_vld, 1'b1);
                check_output("dat_hold", din_rsc_dat, prev_dat);
            end
            if (prev_rx) begin
                pipe.delete(0);
                pipe_t.delete(0);
                rx_seen++;
                last_xfer = cyc;
            end
            case (rdy_mode)
                0:       din_rsc_rdy = 1'b1;
                1:       din_rsc_rdy = ~din_rsc_rdy;
                default: din_rsc_rdy = 1'($urandom_range(0, 1));
            endcase
            if (pipe.size() > 0 && pipe_t[0] <= cyc && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
                dout_rsc_vld = 1'b1;
                dout_rsc_dat = pipe[0];
            end else begin
                dout_rsc_vld = 1'b0;
                dout_rsc_dat = '0;
            end
            prev_tx  = din_rsc_vld && din_rsc_rdy;
            prev_vld = din_rsc_vld;
            prev_dat = din_rsc_dat;
            prev_rx  = dout_rsc_vld && dout_rsc_rdy;
            if (done) done_seen++;
            if (busy && coeffs !== exp_coeffs) coeff_bad++;
        end
    end

    typedef struct {
        logic [FW-1:0] frame;
        logic [63:0]   coeff;
        int            rdy_mode;
        int            vld_mode;
        logic [FW-1:0] exp_out;
        int            exp_lat;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic setup_model(input int rm, input int vm, input int maxr, input bit extra);
        rdy_mode = rm; vld_mode = vm; max_results = maxr; extra_result = extra;
        pipe.delete(); pipe_t.delete();
        res_made = 0; tx_seen = 0; rx_seen = 0; done_seen = 0; coeff_bad = 0;
    endtask

    task automatic apply_stimulus(input logic [FW-1:0] f, input logic [63:0] c, input bit expect_accept);
        frame_in = f;
        coeff_in = c;
        start = 1'b1;
        if (expect_accept) begin
            sb.delete();
            for (int k = 0; k < NUM_SAMP; k++) sb.push_back(f[k*DATA_W +: DATA_W]);
            exp_coeffs = c;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL %s: got no done expected done within 300 cycles", name);
        end
    endtask

    task automatic do_frame(input vec_t v, input bit extra);
        int s;
        setup_model(v.rdy_mode, v.vld_mode, NUM_SAMP, extra);
        apply_stimulus(v.frame, v.coeff, 1'b1);
        s = cyc;
        check_output("start_busy_vld_rdy", {busy, din_rsc_vld, dout_rsc_rdy, err}, 4'b1110);
        check_output("start_clears_frame_out", frame_out, '0);
        wait_done("done_wait");
        if (done) begin
            if (v.exp_lat > 0) check_output("done_latency", cyc - s + 1, v.exp_lat);
            check_output("busy_in_done", busy, 1'b1);
            if (extra) check_output("ninth_not_taken", {dout_rsc_vld, dout_rsc_rdy}, 2'b10);
            step();
            check_output("after_done", {done, busy}, 2'b00);
            if (extra) check_output("ninth_rdy_low", dout_rsc_rdy, 1'b0);
        end
        check_output("frame_out", frame_out, v.exp_out);
        check_output("tx_rx_counts", {tx_seen[15:0], rx_seen[15:0]}, {16'(NUM_SAMP), 16'(NUM_SAMP)});
        check_output("done_pulses", done_seen, 1);
        check_output("coeffs", coeffs, v.coeff);
        check_output("coeffs_stable", coeff_bad, 0);
        check_output("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{64'h0706_0504_0302_0100, 64'h0102_0408_1020_4080, 0, 0, 64'h0807_0605_0403_0201, 11};
        vecs[1] = '{64'hFFFE_FDFC_8080_7F00, 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 64'h00FF_FEFD_8181_8001, 0};
        vecs[2] = '{64'h1122_3344_5566_7788, 64'h0F0F_0F0F_F0F0_F0F0, 2, 1, 64'h1223_3445_5667_7889, 0};
        vecs[3] = '{64'h00FF_00FF_AA55_AA55, 64'h1357_9BDF_2468_ACE0, 0, 0, 64'h0100_0100_AB56_AB56, 11};

        #2 rst = 1'b0;
        repeat (3) step();
        check_output("reset_flags", {busy, done, err, din_rsc_vld, dout_rsc_rdy}, 5'b0);
        check_output("reset_frame_out", frame_out, '0);
        check_output("reset_coeffs", coeffs, '0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            do_frame(vecs[i], 1'b0);
            step();
        end

        $display("[TB] start ignored while busy");
        setup_model(0, 0, NUM_SAMP, 1'b0);
        apply_stimulus(vecs[3].frame, vecs[3].coeff, 1'b1);
        repeat (3) step();
        apply_stimulus(64'hDEAD_DEAD_DEAD_DEAD, 64'h1111_1111_1111_1111, 1'b0);
        wait_done("ignored_done_wait");
        apply_stimulus(64'hBEEF_BEEF_BEEF_BEEF, 64'h2222_2222_2222_2222, 1'b0);
        check_output("done_cycle_start_ignored", busy, 1'b0);
        step();
        check_output("still_idle", {busy, din_rsc_vld}, 2'b00);
        check_output("ignored_frame_out", frame_out, vecs[3].exp_out);
        check_output("ignored_coeffs", coeffs, vecs[3].coeff);
        check_output("ignored_coeffs_stable", coeff_bad, 0);
        check_output("ignored_tx_count", tx_seen, NUM_SAMP);

        $display("[TB] watchdog timeout");
        setup_model(0, 0, 3, 1'b0);
        apply_stimulus(vecs[0].frame, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        n = 0;
        while (!err && !done && n < 300) begin
            step();
            n++;
        end
        check_output("err_set", err, 1'b1);
        check_output("idle_gap", cyc - last_xfer, TIMEOUT);
        check_output("timeout_idle", {busy, din_rsc_vld, dout_rsc_rdy}, 3'b000);
        check_output("timeout_no_done", done_seen, 0);
        check_output("timeout_partial", frame_out, 64'h0000_0000_0003_0201);
        check_output("timeout_counts", {tx_seen[15:0], rx_seen[15:0]}, {16'd8, 16'd3});
        step();
        check_output("err_sticky", err, 1'b1);
        do_frame(vecs[0], 1'b0);

        $display("[TB] reset mid-frame");
        setup_model(0, 0, NUM_SAMP, 1'b0);
        apply_stimulus(vecs[2].frame, vecs[2].coeff, 1'b1);
        n = 0;
        while (tx_seen < 4 && n < 100) begin
            step();
            n++;
        end
        check_output("tx_before_reset", tx_seen, 4);
        rst = 1'b0;
        #1;
        check_output("midreset_flags", {busy, done, err, din_rsc_vld, dout_rsc_rdy}, 5'b0);
        check_output("midreset_data", {din_rsc_dat, frame_out}, '0);
        check_output("midreset_coeffs", coeffs, '0);
        step();
        step();
        rst = 1'b1;
        step();
        do_frame(vecs[0], 1'b0);

        $display("[TB] filter emits nine results");
        do_frame(vecs[3], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_frame_driver.md
# fir_frame_driver

Frame-level producer/consumer for the streaming FIR `top` block. On a single `start` it does three things: captures one frame of samples and a coefficient word, drives the coefficients onto the filter's `coeffs` input, and serializes the samples into the filter's `din_rsc` valid/ready port. It also acts as the sink for the filter's `dout_rsc` port, collecting results into a parallel output frame and then signalling completion. It sits between the system control side and `top`, and owns both ends of the filter's stream handshakes.

## Interface
- `DATA_W`, default 8: sample and coefficient width.
- `NUM_SAMP`, default 8: samples per frame.
- `NUM_TAPS`, default 8: coefficients; `NUM_TAPS*DATA_W` must equal 64.
- `TIMEOUT`, default 256: idle-cycle limit in RUN before abort.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `frame_in`  in  NUM_SAMP*DATA_W  input samples; sample k is bits [k*DATA_W +: DATA_W]; captured on accepted `start`.
- `coeff_in`  in  64  coefficient word; captured on accepted `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a frame completes normally.
- `err`  out  1  sticky timeout flag; cleared on the next accepted `start`.
- `frame_out`  out  NUM_SAMP*DATA_W  collected results; same packing as `frame_in`; held until the next accepted `start`.
- `coeffs`  out  64  registered coefficient word to the filter.
- `din_rsc_dat`  out  DATA_W  sample to the filter.
- `din_rsc_vld`  out  1  sample valid.
- `din_rsc_rdy`  in  1  filter ready.
- `dout_rsc_dat`  in  DATA_W  filter result.
- `dout_rsc_vld`  in  1  result valid.
- `dout_rsc_rdy`  out  1  driver ready for a result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE when the NUM_SAMP-th result is accepted.
  - RUN→IDLE on timeout.
  - DONE→IDLE unconditionally after one cycle.
- Accepted `start` (IDLE only):
  - latches `frame_in` and `coeff_in`;
  - clears `tx_cnt`, `rx_cnt`, the watchdog, `err` and `frame_out`.
  - `start` while `busy`=1 is ignored and has no side effect.
- TX side, in RUN with `tx_cnt`<NUM_SAMP:
  - `din_rsc_vld`=1 and `din_rsc_dat`=sample[`tx_cnt`].
  - A transfer occurs on `din_rsc_vld`&`din_rsc_rdy` at a clock edge; `tx_cnt` then increments.
  - Once `din_rsc_vld` is asserted it stays high, and `din_rsc_dat` stays stable, until the transfer.
  - `din_rsc_vld`=0 otherwise.
- RX side, in RUN with `rx_cnt`<NUM_SAMP:
  - `dout_rsc_rdy`=1.
  - On `dout_rsc_vld`&`dout_rsc_rdy`, `dout_rsc_dat` is written to `frame_out` slot `rx_cnt` and `rx_cnt` increments.
  - Results beyond NUM_SAMP are never accepted (`rdy`=0).
- TX and RX run independently. A TX and an RX transfer in the same cycle are both taken. RX may run ahead of TX count only if the filter does so; the driver does not check ordering.
- `coeffs` updates only on an accepted `start` and is stable for the entire RUN.
- Watchdog:
  - counts RUN cycles with no transfer on either port; it resets on any transfer.
  - Reaching TIMEOUT sets `err`, drops `vld`/`rdy` and returns to IDLE with no `done`.
  - Partial `frame_out` contents are retained.
- Counters are `$clog2(NUM_SAMP+1)` bits wide, so the terminal value NUM_SAMP is representable. There is no wrap-around.
- Reset (any time, including mid-frame):
  - state becomes IDLE;
  - all outputs are 0, including `coeffs`, `frame_out`, `err`, `done`, `busy`, `din_rsc_vld` and `dout_rsc_rdy`.
  - An in-flight handshake is abandoned.

## Timing
- Accepted `start` at edge t: `busy`=1, `din_rsc_vld`=1 and `dout_rsc_rdy`=1 from cycle t+1.
- All outputs are registered or decoded from registered state only. There is no combinational path from `din_rsc_rdy` or `dout_rsc_vld` to any output.
- If the last result is accepted at edge e: `done`=1 and `busy`=1 in cycle e+1; `busy`=0 from e+2.
- Earliest new `start` acceptance: edge e+2.
- With ready filter and filter latency L: start-to-`done` = NUM_SAMP+L+1 cycles.
- `err` rises in the cycle after the TIMEOUT-th idle cycle.

## Structure
- Package `fir_drv_pkg` holds:
  - `DATA_W`, `NUM_SAMP`, `NUM_TAPS` defaults;
  - the state enum `drv_state_t` {IDLE, RUN, DONE};
  - the counter width constant;
  - the `TIMEOUT` default.
- One sub-module, `drv_tx_serializer`: the frame register, `tx_cnt` and the `din_rsc` handshake, with a `load`/`run` input and a `tx_done` output. The FSM, RX collection and the watchdog live in the top level.

## Test plan
- Ready filter model (loopback, `dout` = `din`+1, latency 2), `frame_in`=0x0706050403020100, `start` → `frame_out`=0x0807060504030201; `done` exactly 1 pulse, 11 cycles after `start`.
- `din_rsc_rdy` toggled 1010…, `dout_rsc_vld` random → `din_rsc_vld`/`dat` never change before a transfer; exactly 8 TX and 8 RX transfers; `frame_out` correct.
- `start` pulsed during RUN, and in the `done` cycle → ignored; latched data unchanged; `coeffs` stable at the `coeff_in` captured on the first `start` throughout.
- Filter stalls after 3 results, TIMEOUT=16 → `err`=1 after 16 idle cycles; return to IDLE with no `done`; `frame_out` slots 0–2 filled, rest 0; next `start` clears `err`.
- `rst` asserted mid-frame after 4 TX transfers → all outputs 0 immediately; a subsequent frame completes correctly.
- Filter emitting 9 results → 9th never accepted (`dout_rsc_rdy`=0 after 8).
